// File: rtl/rom_matrix_stream_pkg.sv
// Shared definitions for the ROM matrix streaming device: opcodes, mode bits, FSM states.
package rom_matrix_stream_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDRL = 4'd1;
    localparam logic [3:0] OP_LDRH = 4'd2;
    localparam logic [3:0] OP_LDCL = 4'd3;
    localparam logic [3:0] OP_LDCH = 4'd4;
    localparam logic [3:0] OP_RD   = 4'd5;
    localparam logic [3:0] OP_RDI  = 4'd6;
    localparam logic [3:0] OP_MODE = 4'd7;
    localparam logic [3:0] OP_CLR  = 4'd8;

    localparam int MODE_MAJOR = 0;
    localparam int MODE_STOP  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

endpackage

// File: rtl/matrix_cursor.sv
// Row/column cursor: byte-half loads, clear, and read-and-advance with major/wrap/stop rules.
module matrix_cursor #(
    parameter int RW = 7,
    parameter int CW = 7
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ld_rl,
    input  logic          ld_rh,
    input  logic          ld_cl,
    input  logic          ld_ch,
    input  logic          clr,
    input  logic          adv,
    input  logic          col_major,
    input  logic          stop_mode,
    input  logic [7:0]    imm,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          at_end
);

    localparam logic [RW-1:0] ROW_LAST = '1;
    localparam logic [CW-1:0] COL_LAST = '1;

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [15:0]   row_ext, col_ext;
    logic          row_last, col_last;
    logic          unused_ext;

    assign row_last = (row_q == ROW_LAST);
    assign col_last = (col_q == COL_LAST);
    assign at_end   = row_last & col_last;
    assign row      = row_q;
    assign col      = col_q;

    // Cursor bits above RW/CW are simply dropped after a byte-half load.
    assign unused_ext = ^{row_ext, col_ext};

    // Next cursor: clear wins, then advance, then loads.
    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        row_ext = 16'(row_q);
        col_ext = 16'(col_q);
        if (ld_rl) row_ext[7:0]  = imm;
        if (ld_rh) row_ext[15:8] = imm;
        if (ld_cl) col_ext[7:0]  = imm;
        if (ld_ch) col_ext[15:8] = imm;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (adv) begin
            if (!col_major) begin
                if (!col_last) begin
                    col_d = col_q + 1'b1;
                end else if (!row_last) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else if (!stop_mode) begin
                    row_d = '0;
                    col_d = '0;
                end
            end else begin
                if (!row_last) begin
                    row_d = row_q + 1'b1;
                end else if (!col_last) begin
                    row_d = '0;
                    col_d = col_q + 1'b1;
                end else if (!stop_mode) begin
                    row_d = '0;
                    col_d = '0;
                end
            end
        end else begin
            row_d = row_ext[RW-1:0];
            col_d = col_ext[CW-1:0];
        end
    end

    // Cursor registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/rom_matrix_stream.sv
// Sequencer-attached ROM matrix reader: instruction decode, read FSM, status flags, outputs.
//
// state   | meaning
// IDLE    | accepts any instruction; RD/RDI latch rom_addr from the cursor
// ADDR    | external ROM registers rom_addr
// DATA    | capture ROM word into out, advance cursor for RDI
//
// Any instruction arriving while busy (ADDR or DATA) is dropped and flags error,
// so the next read is accepted once busy has fallen.
module rom_matrix_stream
    import rom_matrix_stream_pkg::*;
#(
    parameter int ROMRows     = 128,
    parameter int ROMCols     = 128,
    parameter int ROMDataSize = 4
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic [11:0]                                  inst,
    input  logic                                         inst_en,
    output logic [ROMDataSize-1:0]                       out,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         error,
    output logic [$clog2(ROMRows)+$clog2(ROMCols)-1:0]   rom_addr,
    input  logic [ROMDataSize-1:0]                       rom_data_o
);

    localparam int RW = $clog2(ROMRows);
    localparam int CW = $clog2(ROMCols);

    state_e                 state_q, state_d;
    logic [ROMDataSize-1:0] out_q, out_d;
    logic [RW+CW-1:0]       addr_q, addr_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic                   major_q, major_d;
    logic                   stop_q, stop_d;
    logic                   rdi_q, rdi_d;

    logic                   ld_rl, ld_rh, ld_cl, ld_ch, clr, adv;
    logic [RW-1:0]          cur_row;
    logic [CW-1:0]          cur_col;
    logic                   at_end;
    logic [3:0]             op;
    logic [7:0]             imm;

    assign op  = inst[11:8];
    assign imm = inst[7:0];

    matrix_cursor #(
        .RW (RW),
        .CW (CW)
    ) u_cursor (
        .clock     (clock),
        .reset     (reset),
        .ld_rl     (ld_rl),
        .ld_rh     (ld_rh),
        .ld_cl     (ld_cl),
        .ld_ch     (ld_ch),
        .clr       (clr),
        .adv       (adv),
        .col_major (major_q),
        .stop_mode (stop_q),
        .imm       (imm),
        .row       (cur_row),
        .col       (cur_col),
        .at_end    (at_end)
    );

    // Instruction decode, FSM next state and status/output next values.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        addr_d  = addr_q;
        done_d  = done_q;
        error_d = error_q;
        major_d = major_q;
        stop_d  = stop_q;
        rdi_d   = rdi_q;
        ld_rl   = 1'b0;
        ld_rh   = 1'b0;
        ld_cl   = 1'b0;
        ld_ch   = 1'b0;
        clr     = 1'b0;
        adv     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inst_en) begin
                    case (op)
                        OP_NOP:  ;
                        OP_LDRL: ld_rl = 1'b1;
                        OP_LDRH: ld_rh = 1'b1;
                        OP_LDCL: ld_cl = 1'b1;
                        OP_LDCH: ld_ch = 1'b1;
                        OP_RD, OP_RDI: begin
                            addr_d  = {cur_row, cur_col};
                            rdi_d   = (op == OP_RDI);
                            state_d = ST_ADDR;
                        end
                        OP_MODE: begin
                            major_d = imm[MODE_MAJOR];
                            stop_d  = imm[MODE_STOP];
                        end
                        OP_CLR: begin
                            clr     = 1'b1;
                            done_d  = 1'b0;
                            error_d = 1'b0;
                        end
                        default: error_d = 1'b1;
                    endcase
                end
            end
            ST_ADDR: begin
                state_d = ST_DATA;
                if (inst_en) error_d = 1'b1;
            end
            ST_DATA: begin
                out_d   = rom_data_o;
                adv     = rdi_q;
                if (rdi_q && at_end && stop_q) done_d = 1'b1;
                state_d = ST_IDLE;
                if (inst_en) error_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, status and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            major_q <= 1'b0;
            stop_q  <= 1'b0;
            rdi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            error_q <= error_d;
            major_q <= major_d;
            stop_q  <= stop_d;
            rdi_q   <= rdi_d;
        end
    end

    assign out      = out_q;
    assign rom_addr = addr_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_rom_matrix_stream.sv
// Scoreboard bench for rom_matrix_stream on a 4x4 ROM whose data equals its address.
module tb_rom_matrix_stream;

    localparam int R = 4;
    localparam int C = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] inst;
    logic        inst_en;
    logic [3:0]  out;
    logic        busy, done, error;
    logic [3:0]  rom_addr;
    logic [3:0]  rom_data_o;

    always #5 clock = ~clock;

    // Synchronous ROM model: data = address.
    always @(posedge clock) rom_data_o <= rom_addr;

    rom_matrix_stream #(
        .ROMRows     (R),
        .ROMCols     (C),
        .ROMDataSize (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .inst       (inst),
        .inst_en    (inst_en),
        .out        (out),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .rom_addr   (rom_addr),
        .rom_data_o (rom_data_o)
    );

    typedef struct {
        int unsigned data;
        int unsigned addr;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: cursor, mode and sticky flags.
    int m_row, m_col;
    bit m_cm, m_stop, m_done, m_err;

    function automatic void chk(string name, int unsigned act, int unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    function automatic void model_reset();
        m_row = 0; m_col = 0; m_cm = 0; m_stop = 0; m_done = 0; m_err = 0;
    endfunction

    // Advance as a linear index through the scan order.
    function automatic void model_adv();
        int idx;
        idx = m_cm ? (m_col * R + m_row) : (m_row * C + m_col);
        if (idx == R * C - 1) begin
            if (m_stop) m_done = 1;
            else idx = 0;
        end else begin
            idx++;
        end
        if (m_cm) begin
            m_col = idx / R; m_row = idx % R;
        end else begin
            m_row = idx / C; m_col = idx % C;
        end
    endfunction

    function automatic void model_issue(logic [3:0] op, logic [7:0] imm);
        exp_t e;
        case (op)
            4'd1: m_row = imm % R;
            4'd3: m_col = imm % C;
            4'd2, 4'd4, 4'd0: ;
            4'd5, 4'd6: begin
                e.addr = m_row * C + m_col;
                e.data = e.addr;
                sb.push_back(e);
                if (op == 4'd6) model_adv();
            end
            4'd7: begin m_cm = imm[0]; m_stop = imm[1]; end
            4'd8: begin m_row = 0; m_col = 0; m_done = 0; m_err = 0; end
            default: m_err = 1;
        endcase
    endfunction

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 8) begin
            @(negedge clock);
            k++;
        end
        if (busy) chk("busy_timeout", 1, 0);
    endtask

    task automatic send(logic [3:0] op, logic [7:0] imm);
        @(negedge clock);
        inst    = {op, imm};
        inst_en = 1'b1;
        model_issue(op, imm);
        @(negedge clock);
        inst_en = 1'b0;
        wait_idle();
    endtask

    // Monitor: a completed read is presented when busy falls.
    bit prev_busy;
    always @(negedge clock or negedge reset) begin
        if (!reset) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out", out, e.data);
                    chk("rom_addr", rom_addr, e.addr);
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset   = 1'b0;
        inst    = '0;
        inst_en = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        chk("rst_out", out, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        reset = 1'b1;

        // RD after reset: busy for exactly two cycles.
        @(negedge clock);
        inst = {4'd5, 8'h00}; inst_en = 1'b1;
        model_issue(4'd5, 8'h00);
        @(negedge clock);
        inst_en = 1'b0;
        chk("busy_c1", busy, 1);
        @(negedge clock);
        chk("busy_c2", busy, 1);
        @(negedge clock);
        chk("busy_c3", busy, 0);
        chk("error_after_rd", error, 0);

        // Load and plain read; second RD confirms the cursor held.
        send(4'd1, 8'd2);
        send(4'd3, 8'd3);
        send(4'd5, 8'd0);
        send(4'd5, 8'd0);

        // Row-major wrap.
        send(4'd7, 8'h00);
        send(4'd1, 8'd3);
        send(4'd3, 8'd2);
        repeat (3) send(4'd6, 8'd0);
        chk("wrap_done", done, 0);
        send(4'd5, 8'd0);

        // Column-major stop.
        send(4'd7, 8'h03);
        send(4'd1, 8'd2);
        send(4'd3, 8'd3);
        send(4'd6, 8'd0);
        chk("stop_done1", done, 0);
        send(4'd6, 8'd0);
        chk("stop_done2", done, 1);
        send(4'd6, 8'd0);
        chk("stop_done3", done, 1);
        send(4'd8, 8'd0);
        chk("clr_done", done, 0);
        send(4'd5, 8'd0);

        // Instruction while busy is dropped.
        @(negedge clock);
        inst = {4'd6, 8'd0}; inst_en = 1'b1;
        model_issue(4'd6, 8'd0);
        @(negedge clock);
        inst = {4'd3, 8'd1};
        m_err = 1;
        @(negedge clock);
        inst_en = 1'b0;
        wait_idle();
        chk("drop_error", error, 1);
        send(4'd5, 8'd0);
        send(4'd8, 8'd0);
        chk("clr_error", error, 0);
        send(4'hF, 8'hA5);
        chk("rsv_error", error, 1);
        chk("rsv_done", done, 0);
        send(4'd5, 8'd0);

        // Randomized instruction stream.
        for (int i = 0; i < 120; i++) begin
            logic [3:0] op;
            logic [7:0] imm;
            op  = 4'($urandom_range(0, 15));
            imm = 8'($urandom);
            send(op, imm);
            chk("rand_error", error, m_err);
            chk("rand_done", done, m_done);
        end

        // Asynchronous reset while in DATA.
        send(4'd7, 8'h03);
        send(4'd1, 8'd3);
        send(4'd3, 8'd1);
        send(4'd5, 8'd0);
        @(negedge clock);
        inst = {4'd5, 8'd0}; inst_en = 1'b1;
        @(negedge clock);
        inst_en = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("arst_out", out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_addr", rom_addr, 0);
        @(negedge clock);
        reset = 1'b1;
        send(4'd5, 8'd0);
        send(4'd6, 8'd0);
        send(4'd5, 8'd0);

        repeat (3) @(negedge clock);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
